mem_arbiter_32: RTL and testbench

// Two-port arbiter/sequencer in front of one mem_32 instance. Port 0 is instruction fetch
// and port 1 is data load/store. The block accepts one request at a time, checks it, drives
// the mem_32 control/address/data pins, captures the 1-cycle-latency read data, and returns
// a response on the owning port. Port 1 has priority over port 0, bounded by a starvation limit.

---
 rtl/mem_arbiter_32.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter_32.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_32.sv
// mem_arbiter_32
// Two-port arbiter and sequencer in front of a single mem_32 instance.
// Port 0 is instruction fetch. Port 1 is data load/store and has priority,
// but that priority is bounded by a starvation limit. Only one request is in
// flight at a time. Each request is checked first; a legal one is driven onto
// the mem_32 pins for one cycle, its read data is captured one cycle later,
// and the response is then held on the owning port until it is consumed.
//
// Ports
//   clk, rst_n                    clock (shared with mem_32), async active-low reset
//   req_valid/req_ready [1:0]     per-port request handshake (bit0 fetch, bit1 data)
//   req_addr  [2*ADDR_BITS-1:0]   per-port byte address
//   req_wdata [63:0]              per-port store data
//   req_wr, req_sign [1:0]        per-port store flag and load sign-extend flag
//   req_len   [3:0]               per-port length: BYTE=0, HALF=1, WORD=2, INVALID=3
//   rsp_valid/rsp_ready [1:0]     per-port response handshake
//   rsp_rdata [31:0], rsp_err     shared response payload, qualified by rsp_valid
//   mem_addr/mem_wdata/mem_wr/mem_len/mem_sign   mem_32 control/address/data pins
//   mem_rdata [31:0]              mem_32 data_out, one cycle of latency
module mem_arbiter_32 #(
  parameter int SIZE        = 1024,
  parameter int ADDR_BITS   = $clog2(SIZE),
  parameter int MAX_STREAK  = 4,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*ADDR_BITS-1:0] req_addr,
  input  logic [63:0]            req_wdata,
  input  logic [1:0]             req_wr,
  input  logic [3:0]             req_len,
  input  logic [1:0]             req_sign,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_wr,
  output logic [1:0]             mem_len,
  output logic                   mem_sign,
  input  logic [31:0]            mem_rdata
);

  localparam logic [1:0] LEN_BYTE    = 2'd0;
  localparam logic [1:0] LEN_HALF    = 2'd1;
  localparam logic [1:0] LEN_WORD    = 2'd2;
  localparam logic [1:0] LEN_INVALID = 2'd3;

  localparam int              SW         = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
  // One extra bit so that addr + nbytes cannot wrap before the bounds compare.
  localparam logic [ADDR_BITS:0] SIZE_W  = (ADDR_BITS + 1)'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [1:0]           len_q, len_d;
  logic                 sign_q, sign_d;
  logic                 id_q, id_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  // Per-port views of the flattened request buses.
  logic [ADDR_BITS-1:0] p_addr  [2];
  logic [31:0]          p_wdata [2];
  logic [1:0]           p_len   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign p_addr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
    assign p_wdata[gi] = req_wdata[gi*32 +: 32];
    assign p_len[gi]   = req_len[gi*2 +: 2];
  end

  // Port 1 wins unless port 0 is waiting and port 1 already used up its streak.
  logic grant1, any_grant, gnt_id;
  assign grant1    = req_valid[1] && !(req_valid[0] && (streak_q == STREAK_MAX));
  assign any_grant = grant1 || req_valid[0];
  assign gnt_id    = grant1;

  logic [ADDR_BITS-1:0] sel_addr;
  logic [1:0]           sel_len;
  logic [ADDR_BITS:0]   nbytes;
  logic [ADDR_BITS:0]   end_addr;
  logic                 misaligned;
  logic                 illegal;

  assign sel_addr = p_addr[gnt_id];
  assign sel_len  = p_len[gnt_id];

  always_comb begin
    nbytes = (ADDR_BITS + 1)'(4);
    case (sel_len)
      LEN_BYTE: nbytes = (ADDR_BITS + 1)'(1);
      LEN_HALF: nbytes = (ADDR_BITS + 1)'(2);
      default:  nbytes = (ADDR_BITS + 1)'(4);
    endcase
  end

  assign end_addr   = {1'b0, sel_addr} + nbytes;
  assign misaligned = (CHECK_ALIGN != 0) &&
                      (((sel_len == LEN_HALF) && sel_addr[0]) ||
                       ((sel_len == LEN_WORD) && (sel_addr[1:0] != 2'b00)));
  assign illegal    = (sel_len == LEN_INVALID) || (end_addr > SIZE_W) || misaligned;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    len_d       = len_q;
    sign_d      = sign_q;
    id_d        = id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (any_grant) begin
          req_ready[gnt_id] = 1'b1;
          addr_d      = sel_addr;
          wdata_d     = p_wdata[gnt_id];
          wr_d        = req_wr[gnt_id];
          len_d       = sel_len;
          sign_d      = req_sign[gnt_id];
          id_d        = gnt_id;
          rsp_err_d   = illegal;
          rsp_rdata_d = 32'h0;
          // The streak only grows while port 0 is actually being held off.
          if (grant1 && req_valid[0]) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
          state_d = illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        rsp_rdata_d = wr_q ? 32'h0 : mem_rdata;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      len_q       <= 2'b00;
      sign_q      <= 1'b0;
      id_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      sign_q      <= sign_d;
      id_q        <= id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Strobes are decoded from state so they drop the instant reset asserts;
  // outside ISSUE the memory sees INVALID and simply holds its data_out.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sign  = sign_q;
  assign mem_wr    = (state_q == S_ISSUE) && wr_q;
  assign mem_len   = (state_q == S_ISSUE) ? len_q : LEN_INVALID;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter_32.sv
// tb_mem_arbiter_32
// Directed bench for mem_arbiter_32 with a stand-in mem_32 (1-cycle read latency).
// A transaction-level model predicts req_ready, rsp_valid, response payload and
// the memory strobes from arbitration/latency rules; a single compare process
// checks the DUT against it every cycle. Directed tests add literal expectations.
module tb_mem_arbiter_32;
  localparam int SIZE = 1024;
  localparam int AB   = 10;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready;
  logic [2*AB-1:0] req_addr;
  logic [63:0]     req_wdata;
  logic [1:0]      req_wr;
  logic [3:0]      req_len;
  logic [1:0]      req_sign;
  logic [1:0]      rsp_valid, rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [AB-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_wr;
  logic [1:0]      mem_len;
  logic            mem_sign;
  logic [31:0]     mem_rdata = 32'h0;

  mem_arbiter_32 #(.SIZE(SIZE), .ADDR_BITS(AB), .MAX_STREAK(MAXS), .CHECK_ALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wr(req_wr), .req_len(req_len), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_len(mem_len),
    .mem_sign(mem_sign), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int wr_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nb(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] len, input logic sg);
    case (len)
      2'd0:    return sg ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      2'd1:    return sg ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Stand-in mem_32: little-endian bytes, writes and reads sampled at the edge.
  logic [7:0] mem_arr [0:SIZE-1];
  always @(posedge clk) begin : mem_model
    int          n;
    logic [31:0] raw;
    if (mem_len != 2'b11) begin
      n   = nb(mem_len);
      raw = 32'h0;
      for (int k = 0; k < n; k++) begin
        if (int'(mem_addr) + k < SIZE) begin
          if (mem_wr) mem_arr[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
          else        raw[8*k +: 8] = mem_arr[int'(mem_addr) + k];
        end
      end
      if (!mem_wr) mem_rdata <= extend(raw, mem_len, mem_sign);
    end
  end

  // Transaction-level reference model and per-cycle compare.
  logic [7:0]  ref_mem [0:SIZE-1];
  bit          m_busy = 0;
  int          m_acc, m_port, m_streak = 0;
  bit          m_err, m_wr;
  logic [1:0]  m_len;
  logic [AB-1:0] m_addr;
  logic [31:0] m_wdata, m_data;

  initial begin : compare
    logic [1:0]  exp_ready, exp_rv, exp_len;
    logic        exp_wr;
    int          p, n;
    logic [31:0] raw;
    forever begin
      @(negedge clk);
      if (mem_wr) wr_total++;
      if (!rst_n) begin
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mem_wr",    32'(mem_wr),    32'h0);
        check("rst_mem_len",   32'(mem_len),   32'h3);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        check("rst_rsp_rdata", rsp_rdata,      32'h0);
        m_busy   = 0;
        m_streak = 0;
      end else begin
        exp_ready = 2'b00;
        if (!m_busy) begin
          if (req_valid[1] && !(req_valid[0] && m_streak == MAXS)) exp_ready = 2'b10;
          else if (req_valid[0])                                   exp_ready = 2'b01;
        end
        exp_rv  = 2'b00;
        exp_wr  = 1'b0;
        exp_len = 2'b11;
        if (m_busy) begin
          if (cyc >= m_acc + (m_err ? 1 : 3)) exp_rv[m_port] = 1'b1;
          if (!m_err && cyc == m_acc + 1) begin
            exp_wr  = m_wr;
            exp_len = m_len;
          end
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("mem_wr",    32'(mem_wr),    32'(exp_wr));
        check("mem_len",   32'(mem_len),   32'(exp_len));
        if (exp_len != 2'b11) begin
          check("mem_addr", 32'(mem_addr), 32'(m_addr));
          if (m_wr) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (exp_rv != 2'b00) begin
          check("rsp_rdata", rsp_rdata,    m_data);
          check("rsp_err",   32'(rsp_err), 32'(m_err));
          if (rsp_ready[m_port]) m_busy = 0;
        end
        if (exp_ready != 2'b00) begin
          p       = exp_ready[1] ? 1 : 0;
          m_port  = p;
          m_acc   = cyc;
          m_busy  = 1;
          m_addr  = req_addr[p*AB +: AB];
          m_wdata = req_wdata[p*32 +: 32];
          m_wr    = req_wr[p];
          m_len   = req_len[p*2 +: 2];
          n       = nb(m_len);
          m_err   = (m_len == 2'd3) || (int'(m_addr) + n > SIZE) ||
                    (m_len == 2'd1 && m_addr[0]) || (m_len == 2'd2 && m_addr[1:0] != 2'b00);
          m_data  = 32'h0;
          if (!m_err) begin
            raw = 32'h0;
            for (int k = 0; k < n; k++) begin
              if (m_wr) ref_mem[int'(m_addr) + k] = m_wdata[8*k +: 8];
              else      raw[8*k +: 8] = ref_mem[int'(m_addr) + k];
            end
            if (!m_wr) m_data = extend(raw, m_len, req_sign[p]);
          end
          m_streak = (p == 1 && req_valid[0]) ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic wr, input logic [1:0] len,
                       input logic [AB-1:0] addr, input logic [31:0] wd, input logic sg);
    req_addr[p*AB +: AB]  = addr;
    req_wdata[p*32 +: 32] = wd;
    req_wr[p]             = wr;
    req_len[p*2 +: 2]     = len;
    req_sign[p]           = sg;
    req_valid[p]          = 1'b1;
  endtask

  task automatic wait_accept(input int p, output int acc);
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 32'(req_ready), 32'(1 << p));
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic collect(input int p, input int acc, output logic [31:0] rd,
                         output logic er, output int lat);
    bit got = 0;
    rd = 32'h0; er = 1'b0; lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin
        got = 1;
        lat = cyc - acc;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
    if (!got) check("rsp_timeout", 32'(rsp_valid), 32'(1 << p));
    if (rsp_ready[p]) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int p, input logic wr, input logic [1:0] len,
                      input logic [AB-1:0] addr, input logic [31:0] wd, input logic sg,
                      output logic [31:0] rd, output logic er, output int lat);
    int acc;
    drive(p, wr, len, addr, wd, sg);
    wait_accept(p, acc);
    collect(p, acc, rd, er, lat);
    $display("txn p%0d %s len=%0d addr=%h wdata=%h sign=%0b -> rdata=%h err=%0b lat=%0d",
             p, wr ? "store" : "load ", len, addr, wd, sg, rd, er, lat);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          lat, w0, acc, n;
    int          seq [10];
    bit          seen;

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_wr = '0;
    req_len = '0; req_sign = '0; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Store/load word
    w0 = wr_total;
    send(1, 1'b1, 2'd2, 10'h010, 32'hDEADBEEF, 1'b0, rd, er, lat);
    check("st_word_lat", 32'(lat), 32'd3);
    check("st_word_err", 32'(er), 32'd0);
    check("st_word_rdata", rd, 32'h0);
    check("st_word_wr_cycles", 32'(wr_total - w0), 32'd1);
    send(0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b0, rd, er, lat);
    check("ld_word_rdata", rd, 32'hDEADBEEF);
    check("ld_word_lat", 32'(lat), 32'd3);

    // Sign extension
    send(1, 1'b1, 2'd0, 10'h021, 32'h00000080, 1'b0, rd, er, lat);
    send(0, 1'b0, 2'd0, 10'h021, 32'h0, 1'b1, rd, er, lat);
    check("ld_byte_signed", rd, 32'hFFFFFF80);
    send(1, 1'b0, 2'd0, 10'h021, 32'h0, 1'b0, rd, er, lat);
    check("ld_byte_unsigned", rd, 32'h00000080);
    send(1, 1'b0, 2'd1, 10'h012, 32'h0, 1'b1, rd, er, lat);
    check("ld_half_signed", rd, 32'hFFFFDEAD);

    // Top-of-memory word (addr + 4 == SIZE is legal)
    send(1, 1'b1, 2'd2, 10'h3FC, 32'h12345678, 1'b0, rd, er, lat);
    check("st_top_err", 32'(er), 32'd0);
    send(0, 1'b0, 2'd2, 10'h3FC, 32'h0, 1'b0, rd, er, lat);
    check("ld_top_rdata", rd, 32'h12345678);

    // Errors
    w0 = wr_total;
    send(1, 1'b0, 2'd2, 10'h022, 32'h0, 1'b0, rd, er, lat);
    check("err_misalign_err", 32'(er), 32'd1);
    check("err_misalign_lat", 32'(lat), 32'd1);
    check("err_misalign_rdata", rd, 32'h0);
    send(1, 1'b1, 2'd3, 10'h000, 32'hFFFFFFFF, 1'b0, rd, er, lat);
    check("err_len3_err", 32'(er), 32'd1);
    send(0, 1'b0, 2'd1, 10'h3FF, 32'h0, 1'b0, rd, er, lat);
    check("err_half_top_err", 32'(er), 32'd1);
    check("err_no_mem_wr", 32'(wr_total - w0), 32'd0);

    // Backpressure on port 0 while port 1 waits
    rsp_ready = 2'b10;
    send(0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b0, rd, er, lat);
    @(posedge clk);
    #1 drive(1, 1'b0, 2'd2, 10'h3FC, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    wait_accept(1, acc);
    collect(1, acc, rd, er, lat);
    check("bp_p1_rdata", rd, 32'h12345678);

    // Starvation bound: p1 x4, p0, p1 x4, p0
    drive(0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b0);
    drive(1, 1'b0, 2'd2, 10'h3FC, 32'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 300 && n < 10; i++) begin
      @(negedge clk);
      if (req_ready[1])      begin seq[n] = 1; n++; end
      else if (req_ready[0]) begin seq[n] = 0; n++; end
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    check("starve_grants", 32'(n), 32'd10);
    for (int i = 0; i < n; i++) check("starve_seq", 32'(seq[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
    $display("txn starvation grant sequence: %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d",
             seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7], seq[8], seq[9]);

    // Reset during WAIT
    drive(0, 1'b0, 2'd2, 10'h010, 32'h0, 1'b0);
    wait_accept(0, acc);      // now in ISSUE
    @(posedge clk);           // now in WAIT
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mid_mem_wr",    32'(mem_wr),    32'h0);
    check("rst_mid_mem_len",   32'(mem_len),   32'h3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'h0);
    $display("txn reset during WAIT, response suppressed=%0b", !seen);
    @(posedge clk); #1;
    send(0, 1'b0, 2'd2, 10'h3FC, 32'h0, 1'b0, rd, er, lat);
    check("post_rst_rdata", rd, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end
endmodule
